// File: rtl/ldo_pkg.sv
// Shared definitions for the LDO segment sequencers: array sizes, the
// sequencer state encoding and thermometer-code helper functions.
package ldo_pkg;

    localparam int N_SEG = 64;
    localparam int CNT_W = 7;
    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RAMP = 2'd1,
        S_OFF  = 2'd2
    } seq_state_e;

    // Count of ON segments -> active-high thermometer (bit i set when i < count).
    function automatic logic [N_SEG-1:0] bin2therm(input logic [CNT_W-1:0] count);
        logic [N_SEG-1:0] therm;
        therm = '0;
        for (int i = 0; i < N_SEG; i++) begin
            therm[i] = (i < int'(count));
        end
        return therm;
    endfunction

    // Active-low code is legal when its inverse is 2^k-1 (zeros packed at the bottom).
    function automatic logic therm_valid(input logic [N_SEG-1:0] code_n);
        logic [N_SEG-1:0] on_mask;
        on_mask = ~code_n;
        return ((on_mask & (on_mask + N_SEG'(1))) == '0);
    endfunction

    // Number of ON (low) bits in an active-low code.
    function automatic logic [CNT_W-1:0] therm2bin(input logic [N_SEG-1:0] code_n);
        logic [CNT_W-1:0] count;
        count = '0;
        for (int i = 0; i < N_SEG; i++) begin
            if (!code_n[i]) begin
                count = count + CNT_W'(1);
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/therm_code_check.sv
// Registered thermometer validator/encoder. A legal code updates the count
// one cycle later; an illegal code leaves the count alone and sets a sticky
// error. Narrower buses are padded with OFF bits so the shared helpers apply.
module therm_code_check
    import ldo_pkg::*;
#(
    parameter int W  = N_SEG,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  code_n,
    input  logic          err_clr,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          err
);

    logic [N_SEG-1:0] ext_n;
    logic             code_ok;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             err_d, err_q;

    // Decode the code; a new illegal code beats a simultaneous clear.
    always_comb begin
        ext_n          = '1;
        ext_n[W-1:0]   = code_n;
        code_ok        = therm_valid(ext_n);
        cnt_d          = cnt_q;
        err_d          = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (code_ok) begin
            cnt_d = CW'(therm2bin(ext_n));
        end else begin
            err_d = 1'b1;
        end
    end

    // Accepted count and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign err     = err_q;

endmodule

// File: rtl/dldo_seg_sequencer.sv
// DLDO power-switch sequencer: slews the ON-segment count toward the accepted
// target one segment per step interval, with emergency force-off and a
// settled flag. The drive to the analog array is a registered thermometer.
module dldo_seg_sequencer
    import ldo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_SEG-1:0] tgt_en_n,
    input  logic [DIV_W-1:0] step_div,
    input  logic             force_off,
    input  logic             err_clr,
    output logic [N_SEG-1:0] seg_en_n,
    output logic [CNT_W-1:0] cur_count,
    output logic             settled,
    output logic             code_err
);

    logic [N_SEG-1:0] tgt_d, tgt_q;
    logic [CNT_W-1:0] tgt_cnt, tgt_cnt_nxt;
    seq_state_e       state_d, state_q;
    logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
    logic [CNT_W-1:0] cur_count_d, cur_count_q;
    logic [CNT_W-1:0] step_cnt;
    logic [N_SEG-1:0] seg_en_n_d, seg_en_n_q;
    logic             settled_d, settled_q;

    therm_code_check #(
        .W  (N_SEG),
        .CW (CNT_W)
    ) u_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .code_n  (tgt_q),
        .err_clr (err_clr),
        .cnt     (tgt_cnt),
        .cnt_nxt (tgt_cnt_nxt),
        .err     (code_err)
    );

    // Next-state logic: the edge leaving S_HOLD counts as the first divider
    // tick, so a fresh target steps step_div+1 cycles after it is accepted.
    always_comb begin
        tgt_d       = tgt_en_n;
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        cur_count_d = cur_count_q;
        step_cnt    = (tgt_cnt > cur_count_q) ? cur_count_q + CNT_W'(1)
                                              : cur_count_q - CNT_W'(1);
        if (force_off) begin
            state_d     = S_OFF;
            cur_count_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (tgt_cnt == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d   = S_RAMP;
                        div_cnt_d = step_div;
                    end
                end
                S_HOLD: begin
                    if (enable && (tgt_cnt != cur_count_q)) begin
                        if (step_div == '0) begin
                            cur_count_d = step_cnt;
                            div_cnt_d   = '0;
                            state_d     = (step_cnt == tgt_cnt) ? S_HOLD : S_RAMP;
                        end else begin
                            div_cnt_d = step_div - DIV_W'(1);
                            state_d   = S_RAMP;
                        end
                    end
                end
                S_RAMP: begin
                    if (enable) begin
                        if (tgt_cnt == cur_count_q) begin
                            state_d = S_HOLD;
                        end else if (div_cnt_q == '0) begin
                            cur_count_d = step_cnt;
                            div_cnt_d   = step_div;
                            if (step_cnt == tgt_cnt) begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            div_cnt_d = div_cnt_q - DIV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d     = S_HOLD;
                    cur_count_d = '0;
                end
            endcase
        end
        seg_en_n_d = ~bin2therm(cur_count_d);
        settled_d  = !force_off && (cur_count_d == tgt_cnt_nxt);
    end

    // State, divider, count and analog drive registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q       <= '1;
            state_q     <= S_HOLD;
            div_cnt_q   <= '0;
            cur_count_q <= '0;
            seg_en_n_q  <= '1;
            settled_q   <= 1'b1;
        end else begin
            tgt_q       <= tgt_d;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            cur_count_q <= cur_count_d;
            seg_en_n_q  <= seg_en_n_d;
            settled_q   <= settled_d;
        end
    end

    assign seg_en_n  = seg_en_n_q;
    assign cur_count = cur_count_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_dldo_seg_sequencer.sv
// Directed bench for the DLDO segment sequencer. Expected values are queued
// per edge (edges numbered from the first clock after a stimulus change)
// and popped/compared just after each rising edge.
module tb_dldo_seg_sequencer;

    localparam int K_CNT     = 0;
    localparam int K_SEG     = 1;
    localparam int K_SETTLED = 2;
    localparam int K_ERR     = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [63:0] tgt_en_n;
    logic [7:0]  step_div;
    logic        force_off;
    logic        err_clr;
    logic [63:0] seg_en_n;
    logic [6:0]  cur_count;
    logic        settled;
    logic        code_err;

    typedef struct {
        int          edgeNo;
        int          kind;
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edgeIdx    = 0;

    dldo_seg_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tgt_en_n  (tgt_en_n),
        .step_div  (step_div),
        .force_off (force_off),
        .err_clr   (err_clr),
        .seg_en_n  (seg_en_n),
        .cur_count (cur_count),
        .settled   (settled),
        .code_err  (code_err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [63:0] thermN(input int n);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t[i] = 1'b1;
        return t;
    endfunction

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_CNT:     return 64'(cur_count);
            K_SEG:     return seg_en_n;
            K_SETTLED: return 64'(settled);
            default:   return 64'(code_err);
        endcase
    endfunction

    task automatic pushExpect(input int e, input int kind, input string tag, input logic [63:0] v);
        exp_t x;
        x.edgeNo = e;
        x.kind   = kind;
        x.tag    = tag;
        x.val    = v;
        sb.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t        x;
        logic [63:0] obs;
        while (sb.size() > 0 && sb[0].edgeNo == edgeIdx) begin
            x   = sb.pop_front();
            obs = observe(x.kind);
            compared++;
            assert (obs === x.val) else begin
                mismatched++;
                $error("[TB] FAIL %s edge %0d: observed %h expected %h", x.tag, edgeIdx, obs, x.val);
            end
        end
    endtask

    task automatic checkNow();
        int saved;
        saved   = edgeIdx;
        edgeIdx = -1;
        checkOutput();
        edgeIdx = saved;
    endtask

    task automatic applyStimulus(input logic [63:0] tgt, input logic [7:0] div, input logic en);
        tgt_en_n = tgt;
        step_div = div;
        enable   = en;
        edgeIdx  = 0;
    endtask

    task automatic runEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput();
            edgeIdx++;
        end
    endtask

    initial begin
        logic [63:0] allOff;
        logic [63:0] badCode;
        allOff    = '1;
        badCode   = 64'h0000_0000_0000_00F0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        tgt_en_n  = allOff;
        step_div  = 8'd0;
        force_off = 1'b0;
        err_clr   = 1'b0;

        // Reset values while held in reset.
        #12;
        pushExpect(-1, K_CNT,     "rst_count",   64'd0);
        pushExpect(-1, K_SEG,     "rst_seg",     allOff);
        pushExpect(-1, K_SETTLED, "rst_settled", 64'd1);
        pushExpect(-1, K_ERR,     "rst_err",     64'd0);
        checkNow();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp up 0 -> 8, one segment per cycle.
        $display("[TB] ramp 0->8 step_div=0");
        for (int e = 0; e <= 10; e++) begin
            pushExpect(e, K_CNT, "p1_count", 64'((e < 2) ? 0 : ((e - 1 > 8) ? 8 : e - 1)));
            if (e == 1) pushExpect(e, K_SETTLED, "p1_settled_lo", 64'd0);
            if (e == 9) begin
                pushExpect(e, K_SEG,     "p1_seg",        ~64'hFF);
                pushExpect(e, K_SETTLED, "p1_settled_hi", 64'd1);
            end
        end
        applyStimulus(~64'hFF, 8'd0, 1'b1);
        runEdges(11);

        // Ramp down 8 -> 0 every 4 cycles, never below zero.
        $display("[TB] ramp 8->0 step_div=3");
        for (int e = 0; e <= 36; e++) begin
            int c;
            c = (e < 5) ? 8 : 8 - ((e - 5) / 4 + 1);
            if (c < 0) c = 0;
            pushExpect(e, K_CNT, "p2_count", 64'(c));
            if (e == 2)  pushExpect(e, K_SETTLED, "p2_settled_lo", 64'd0);
            if (e == 33) pushExpect(e, K_SETTLED, "p2_settled_hi", 64'd1);
            if (e == 34) pushExpect(e, K_SEG,     "p2_seg",        allOff);
        end
        applyStimulus(allOff, 8'd3, 1'b1);
        runEdges(37);

        // Corrupt code: flagged, count held; clear loses to a live bad code.
        $display("[TB] invalid target code");
        pushExpect(1, K_ERR, "p3_err_set",  64'd1);
        pushExpect(1, K_CNT, "p3_count",    64'd0);
        pushExpect(4, K_CNT, "p3_count_hold", 64'd0);
        pushExpect(4, K_ERR, "p3_err_hold", 64'd1);
        applyStimulus(badCode, 8'd3, 1'b1);
        runEdges(5);
        pushExpect(5, K_ERR, "p3_set_wins", 64'd1);
        err_clr = 1'b1;
        runEdges(1);
        err_clr  = 1'b0;
        tgt_en_n = allOff;
        pushExpect(7, K_ERR, "p3_err_before_clr", 64'd1);
        runEdges(2);
        pushExpect(8, K_ERR, "p3_err_cleared", 64'd0);
        pushExpect(9, K_ERR, "p3_err_stays",   64'd0);
        pushExpect(9, K_CNT, "p3_count_end",   64'd0);
        err_clr = 1'b1;
        runEdges(1);
        err_clr = 1'b0;
        runEdges(1);

        // Force-off mid-ramp 0 -> 20, then resume from zero.
        $display("[TB] force_off mid-ramp");
        pushExpect(11, K_CNT,     "p4_count_pre",  64'd10);
        pushExpect(11, K_SEG,     "p4_seg_pre",    ~thermN(10));
        pushExpect(12, K_CNT,     "p4_off_count",  64'd0);
        pushExpect(12, K_SEG,     "p4_off_seg",    allOff);
        pushExpect(12, K_SETTLED, "p4_off_settled", 64'd0);
        pushExpect(16, K_CNT,     "p4_off_hold",   64'd0);
        pushExpect(16, K_SETTLED, "p4_off_settled2", 64'd0);
        pushExpect(17, K_CNT,     "p4_release",    64'd0);
        pushExpect(18, K_CNT,     "p4_resume1",    64'd1);
        pushExpect(27, K_CNT,     "p4_resume10",   64'd10);
        pushExpect(37, K_CNT,     "p4_done",       64'd20);
        pushExpect(37, K_SEG,     "p4_done_seg",   ~thermN(20));
        pushExpect(37, K_SETTLED, "p4_done_settled", 64'd1);
        pushExpect(38, K_CNT,     "p4_no_overshoot", 64'd20);
        applyStimulus(~thermN(20), 8'd0, 1'b1);
        runEdges(12);
        force_off = 1'b1;
        runEdges(5);
        force_off = 1'b0;
        runEdges(22);

        // Return to zero, then ramp 0 -> 30 reversed to 5 at count 12.
        $display("[TB] reversal mid-ramp");
        pushExpect(22, K_CNT,     "p5_zero",         64'd0);
        pushExpect(22, K_SETTLED, "p5_zero_settled", 64'd1);
        applyStimulus(allOff, 8'd0, 1'b1);
        runEdges(23);
        pushExpect(11, K_CNT, "p5_up10", 64'd10);
        pushExpect(12, K_CNT, "p5_up11", 64'd11);
        pushExpect(13, K_CNT, "p5_peak", 64'd12);
        pushExpect(14, K_CNT, "p5_rev",  64'd11);
        pushExpect(20, K_CNT, "p5_low",  64'd5);
        pushExpect(20, K_SETTLED, "p5_settled", 64'd1);
        pushExpect(21, K_CNT, "p5_hold", 64'd5);
        applyStimulus(~thermN(30), 8'd0, 1'b1);
        runEdges(12);
        tgt_en_n = ~thermN(5);
        runEdges(10);

        // Freeze with enable low, then resume toward 40.
        $display("[TB] enable freeze");
        pushExpect(2, K_SETTLED, "p5_frz_settled",  64'd0);
        pushExpect(5, K_CNT,     "p5_frz_count",    64'd5);
        pushExpect(5, K_SETTLED, "p5_frz_settled2", 64'd0);
        applyStimulus(~thermN(40), 8'd0, 1'b0);
        runEdges(6);
        enable = 1'b1;
        pushExpect(6,  K_CNT, "p6_go",  64'd6);
        pushExpect(15, K_CNT, "p6_c15", 64'd15);
        runEdges(10);
        tgt_en_n = badCode;
        pushExpect(17, K_CNT, "p6_c17",   64'd17);
        pushExpect(17, K_SEG, "p6_seg17", ~thermN(17));
        pushExpect(17, K_ERR, "p6_err",   64'd1);
        runEdges(2);

        // Asynchronous reset mid-ramp, between clock edges.
        $display("[TB] async reset mid-ramp");
        #2;
        rst_n = 1'b0;
        #1;
        pushExpect(-1, K_SEG,     "p6_rst_seg",     allOff);
        pushExpect(-1, K_CNT,     "p6_rst_count",   64'd0);
        pushExpect(-1, K_SETTLED, "p6_rst_settled", 64'd1);
        pushExpect(-1, K_ERR,     "p6_rst_err",     64'd0);
        checkNow();
        applyStimulus(allOff, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pushExpect(2, K_CNT,     "p6_post_count",   64'd0);
        pushExpect(2, K_SETTLED, "p6_post_settled", 64'd1);
        pushExpect(2, K_ERR,     "p6_post_err",     64'd0);
        runEdges(3);

        compared++;
        assert (sb.size() === 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
